// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse_meter gated edge counter.
// FSM encodings are fixed so debug taps and checkers can decode state_dbg directly.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam int DEF_GATE_CYCLES = 1000;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Timer only ever needs to reach GATE_CYCLES-1.
    function automatic int timer_width(input int gate_cycles);
        return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/pulse_meter_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin followed by a history flop,
// producing a single-cycle pulse on each synchronised rising edge.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pulse_meter.sv
// Counts synchronised rising edges of sig_in over a GATE_CYCLES-clock window and
// presents each completed result on a count_valid/ack handshake.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             ena,
    input  logic             ack,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int               TW        = timer_width(GATE_CYCLES);
    localparam logic [TW-1:0]    LAST_TICK = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Handshake: a result transfers on any clock edge where count_valid and ack are both
    // high; count_valid then drops and count_out/overflow stay put until the next window.

    state_t             state, state_nxt;
    logic [TW-1:0]      timer;
    logic [CNT_W-1:0]   acc, acc_nxt;
    logic               ovf_acc, ovf_nxt;
    logic               rise;

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(sig_in),
        .rise    (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (ena) state_nxt = ST_MEASURE;
            ST_MEASURE: begin
                if (!ena)                   state_nxt = ST_IDLE;
                else if (timer == LAST_TICK) state_nxt = ST_HOLD;
            end
            ST_HOLD:    if (ack) state_nxt = ena ? ST_MEASURE : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Saturating accumulate; the final-cycle rise is folded in before latching.
    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf_acc;
        if (rise) begin
            if (acc != CNT_MAX) acc_nxt = acc + CNT_W'(1);
            else                ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            acc         <= '0;
            ovf_acc     <= 1'b0;
            count_out   <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ena) begin
                        timer   <= '0;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (ena) begin
                        timer   <= timer + TW'(1);
                        acc     <= acc_nxt;
                        ovf_acc <= ovf_nxt;
                        if (timer == LAST_TICK) begin
                            count_out   <= acc_nxt;
                            overflow    <= ovf_nxt;
                            count_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (ack) begin
                        count_valid <= 1'b0;
                        timer       <= '0;
                        acc         <= '0;
                        ovf_acc     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == ST_MEASURE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: table of pulse windows plus hand sequences for hold, abort,
// saturation and asynchronous reset; results checked through expected-value queues.
module tb_pulse_meter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sig_in, ena, ack;
    logic [7:0] count_out;
    logic       count_valid, overflow, busy;
    logic [1:0] state_dbg;

    logic       sig2, ena2, ack2;
    logic [3:0] count2;
    logic       valid2, ovf2, busy2;
    logic [1:0] state2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [4:0] exp2_q[$];

    typedef struct {
        int         start;
        int         n;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[7];

    pulse_meter #(.GATE_CYCLES(16), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ena(ena), .ack(ack),
        .count_out(count_out), .count_valid(count_valid), .overflow(overflow),
        .busy(busy), .state_dbg(state_dbg)
    );

    pulse_meter #(.GATE_CYCLES(64), .CNT_W(4), .SYNC_STAGES(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .sig_in(sig2), .ena(ena2), .ack(ack2),
        .count_out(count2), .count_valid(valid2), .overflow(ovf2),
        .busy(busy2), .state_dbg(state2)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic pulse_at(input int t, input int start, input int n,
                                      input int hi, input int per);
        for (int k = 0; k < n; k++)
            if (t >= start + per * k && t < start + per * k + hi) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- scoreboards ----------------
    logic prev_valid  = 1'b0;
    logic prev_valid2 = 1'b0;

    always @(negedge clk) begin
        if (rst_n && count_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(count_out), 32'hffff_ffff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("result_count", 32'(count_out), 32'(e[7:0]));
                check("result_ovf", 32'(overflow), 32'(e[8]));
            end
        end
        prev_valid = count_valid;
    end

    always @(negedge clk) begin
        if (rst_n && valid2 && !prev_valid2) begin
            if (exp2_q.size() == 0) begin
                check("small_unexpected_result", 32'(count2), 32'hffff_ffff);
            end else begin
                logic [4:0] e;
                e = exp2_q.pop_front();
                check("small_count", 32'(count2), 32'(e[3:0]));
                check("small_ovf", 32'(ovf2), 32'(e[4]));
            end
        end
        prev_valid2 = valid2;
    end

    // ---------------- driver tasks ----------------
    // Pulses of 2 high / 3 low start at t = start + 5k; ena rises at t = 0.
    task automatic measure_window(input int start, input int n, input logic [7:0] exp_count);
        exp_q.push_back({1'b0, exp_count});
        for (int t = -2; t <= 16; t++) begin
            sig_in = pulse_at(t, start, n, 2, 5);
            ena    = (t >= 0);
            step();
            if (t == 15) begin
                check("valid_before_gate_end", 32'(count_valid), 32'd0);
                check("busy_last_cycle", 32'(busy), 32'd1);
            end
            if (t == 16) begin
                check("valid_at_gate_end", 32'(count_valid), 32'd1);
                check("busy_in_hold", 32'(busy), 32'd0);
                check("state_hold", 32'(state_dbg), 32'd2);
            end
        end
    endtask

    // Hold with sig_in toggling and ack low, then one ack cycle.
    task automatic hold_and_release(input logic [7:0] exp_count, input logic keep_ena);
        for (int h = 0; h < 8; h++) begin
            sig_in = (h < 5) ? h[0] : 1'b0;
            step();
            check("hold_valid", 32'(count_valid), 32'd1);
            check("hold_count", 32'(count_out), 32'(exp_count));
        end
        ack = 1'b1;
        ena = keep_ena;
        step();
        ack = 1'b0;
        check("valid_after_ack", 32'(count_valid), 32'd0);
        check("count_kept_after_ack", 32'(count_out), 32'(exp_count));
        check("busy_after_ack", 32'(busy), 32'(keep_ena));
    endtask

    task automatic small_window(input int n, input logic [3:0] exp_count, input logic exp_ovf);
        exp2_q.push_back({exp_ovf, exp_count});
        for (int t = 0; t <= 64; t++) begin
            sig2 = pulse_at(t, 0, n, 1, 3);
            ena2 = 1'b1;
            step();
            if (t == 63) check("small_valid_early", 32'(valid2), 32'd0);
            if (t == 64) check("small_valid_end", 32'(valid2), 32'd1);
        end
        ack2 = 1'b1;
        ena2 = 1'b0;
        step();
        ack2 = 1'b0;
        check("small_valid_after_ack", 32'(valid2), 32'd0);
        repeat (3) step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{start: -1, n: 4, exp_count: 8'd4};  // four pulses across the whole window
        vecs[1] = '{start:  0, n: 3, exp_count: 8'd3};
        vecs[2] = '{start: -2, n: 4, exp_count: 8'd3};  // first rise lands in IDLE
        vecs[3] = '{start:  2, n: 0, exp_count: 8'd0};
        vecs[4] = '{start: 14, n: 1, exp_count: 8'd1};  // rise on the last window cycle
        vecs[5] = '{start: 10, n: 2, exp_count: 8'd1};  // second rise lands in HOLD
        vecs[6] = '{start:  1, n: 3, exp_count: 8'd3};

        rst_n = 1'b0;
        sig_in = 1'b0; ena = 1'b0; ack = 1'b0;
        sig2 = 1'b0; ena2 = 1'b0; ack2 = 1'b0;
        repeat (2) step();
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_valid", 32'(count_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // ack with nothing pending is ignored
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("idle_ack_valid", 32'(count_valid), 32'd0);
        check("idle_ack_state", 32'(state_dbg), 32'd0);

        for (int i = 0; i < 7; i++) begin
            measure_window(vecs[i].start, vecs[i].n, vecs[i].exp_count);
            hold_and_release(vecs[i].exp_count, 1'b0);
            repeat (3) step();
        end

        // Release from HOLD straight into a fresh window with ena held high.
        measure_window(0, 3, 8'd3);
        hold_and_release(8'd3, 1'b1);
        check("restart_state", 32'(state_dbg), 32'd1);
        exp_q.push_back({1'b0, 8'd0});
        for (int t = 1; t <= 16; t++) begin
            sig_in = 1'b0;
            step();
            if (t == 15) check("restart_valid_early", 32'(count_valid), 32'd0);
            if (t == 16) check("restart_valid_end", 32'(count_valid), 32'd1);
        end
        hold_and_release(8'd0, 1'b0);
        repeat (3) step();

        // Set up a prior count of 4, then abort a window at timer==8 after 3 rises.
        measure_window(-1, 4, 8'd4);
        hold_and_release(8'd4, 1'b0);
        repeat (3) step();
        for (int t = -1; t <= 9; t++) begin
            sig_in = pulse_at(t, -1, 3, 1, 3);
            ena    = (t >= 0 && t < 9);
            step();
            if (t == 8) check("abort_busy_before", 32'(busy), 32'd1);
        end
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            sig_in = 1'b0;
            step();
            if (i % 5 == 0) begin
                check("abort_no_valid", 32'(count_valid), 32'd0);
                check("abort_count_kept", 32'(count_out), 32'd4);
            end
        end

        // Saturation on the narrow instance, then a normal window clears overflow.
        small_window(20, 4'd15, 1'b1);
        small_window(3, 4'd3, 1'b0);

        // Asynchronous reset mid-window.
        for (int t = 0; t < 8; t++) begin
            sig_in = pulse_at(t, 0, 3, 2, 5);
            ena    = 1'b1;
            step();
        end
        check("pre_reset_count", 32'(count_out), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count_out), 32'd0);
        check("async_rst_valid", 32'(count_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_state", 32'(state_dbg), 32'd0);
        ena = 1'b0;
        sig_in = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_state", 32'(state_dbg), 32'd0);
        measure_window(-1, 4, 8'd4);
        hold_and_release(8'd4, 1'b0);
        repeat (3) step();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("exp2_q_drained", 32'(exp2_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
